// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled tick counter.
// Direction and overflow-mode encodings, plus prescaler sizing.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   typedef enum logic [1:0] {
      OpHold,
      OpStep,
      OpLoad,
      OpClr
   } counter_op_e;

   // A divide-by-one prescaler still keeps a 1-bit register so the port widths stay legal.
   function automatic int unsigned pre_width(input int unsigned clk_div);
      return (clk_div <= 1) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled and flags the terminal cycle.
// oTICK_PRE is combinational; the counter registers it alongside its own update.
module tick_gen
   import counter_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic iCLK_50,
   input  logic iRST,
   input  logic iEN,
   input  logic iCLR,
   output logic oTICK_PRE
);

   localparam int unsigned   PW   = pre_width(CLK_DIV);
   localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;

   always_comb begin
      oTICK_PRE = iEN && (pre_q == TERM);
      pre_d     = pre_q;
      if (iCLR) begin
         pre_d = '0;
      end else if (oTICK_PRE) begin
         pre_d = '0;
      end else if (iEN) begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/tick_counter.sv
// Prescaled up/down counter with run-time wrap/saturate, load and clear.
// Count, tick and terminal-count pulses all update on the prescaler's terminal edge.
module tick_counter
   import counter_pkg::*;
#(
   parameter int unsigned      CLK_DIV = 50_000_000,
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] INIT    = '0
) (
   input  logic             iCLK_50,
   input  logic             iRST,
   input  logic             iEN,
   input  logic             iDIR,
   input  logic             iSAT,
   input  logic             iCLR,
   input  logic             iLOAD,
   input  logic [WIDTH-1:0] iLOAD_VAL,
   output logic [WIDTH-1:0] oCOUNT,
   output logic             oTICK,
   output logic             oTC
);

   logic             tick;
   logic             at_bound;
   counter_op_e      op;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             tc_q, tc_d;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .iCLK_50   (iCLK_50),
      .iRST      (iRST),
      .iEN       (iEN),
      .iCLR      (iCLR),
      .oTICK_PRE (tick)
   );

   always_comb begin
      at_bound = (iDIR == DIR_UP) ? (cnt_q == '1) : (cnt_q == '0);

      if (iCLR) begin
         op = OpClr;
      end else if (iLOAD) begin
         op = OpLoad;
      end else if (tick) begin
         op = OpStep;
      end else begin
         op = OpHold;
      end

      cnt_d  = cnt_q;
      tick_d = 1'b0;
      tc_d   = 1'b0;
      unique case (op)
         OpClr: begin
            cnt_d = INIT;
         end
         OpLoad: begin
            // A load swallows the step but the prescaler still reports its tick.
            cnt_d  = iLOAD_VAL;
            tick_d = tick;
         end
         OpStep: begin
            tick_d = 1'b1;
            tc_d   = at_bound;
            if (at_bound && (iSAT == MODE_SAT)) begin
               cnt_d = cnt_q;
            end else if (iDIR == DIR_UP) begin
               cnt_d = cnt_q + WIDTH'(1);
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
         OpHold: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         cnt_q  <= INIT;
         tick_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         tc_q   <= tc_d;
      end
   end

   assign oCOUNT = cnt_q;
   assign oTICK  = tick_q;
   assign oTC    = tc_q;

endmodule
